instr_fetch: RTL and testbench

- Fetch stage of the RV32I core. Issues word reads to instruction memory and buffers returned instructions with their PCs in a small FIFO.
- Presents instructions to decode over a valid/ready interface. The decoder drives immsrc, and the immediate extender consumes instr from this block.
- instr_pc is exported so that downstream can form PC+immext branch and jump targets.
- Handles redirects from taken branches and jumps, including flushing and discarding a stale in-flight response.

---
 rtl/instr_fetch_if.sv | 25 ++
 rtl/instr_fetch.sv | 100 ++++++++++
 tb/tb_instr_fetch.sv | 364 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: instruction memory port, redirect input and the
// instruction stream handed to decode.
`timescale 1ns/1ps
interface instr_fetch_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_rvalid, imem_rdata, redirect_valid, redirect_pc, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_rvalid, imem_rdata, redirect_valid, redirect_pc, instr_ready
  );
endinterface

// File: rtl/instr_fetch.sv
// RV32I fetch stage: one outstanding word read at a time, responses buffered
// with their PCs in a small FIFO; redirects flush and drop stale responses.
`timescale 1ns/1ps
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  instr_fetch_if.master bus
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {StFetch, StWait, StDrain} state_e;

  state_e            state_q;
  logic [31:0]       pc_q;
  logic [31:0]       req_pc_q;
  logic [CntW-1:0]   count_q;
  logic [CntW-1:0]   count_d;
  logic [PtrW-1:0]   rd_ptr_q;
  logic [PtrW-1:0]   wr_ptr_q;
  logic [31:0]       instr_mem [DEPTH];
  logic [31:0]       pc_mem    [DEPTH];

  logic fetch_go;
  logic push;
  logic pop;
  logic unused_redirect_lsb;

  assign unused_redirect_lsb = ^bus.redirect_pc[1:0];

  assign fetch_go = reset_n && (state_q == StFetch) && (count_q < CntW'(DEPTH)) &&
                    !bus.redirect_valid;
  assign push     = (state_q == StWait) && bus.imem_rvalid && !bus.redirect_valid;
  assign pop      = (count_q != '0) && bus.instr_ready && !bus.redirect_valid;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= StFetch;
      pc_q     <= RESET_PC;
      req_pc_q <= RESET_PC;
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else if (bus.redirect_valid) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      pc_q     <= {bus.redirect_pc[31:2], 2'b00};
      // The one outstanding response (if any) must still be absorbed.
      unique case (state_q)
        StWait, StDrain: state_q <= bus.imem_rvalid ? StFetch : StDrain;
        default:         state_q <= StFetch;
      endcase
    end else begin
      count_q <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case (state_q)
        StFetch: begin
          if (fetch_go) begin
            pc_q     <= pc_q + 32'd4;
            req_pc_q <= pc_q;
            state_q  <= StWait;
          end
        end
        StWait, StDrain: begin
          if (bus.imem_rvalid) state_q <= StFetch;
        end
        default: state_q <= StFetch;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr_q] <= bus.imem_rdata;
      pc_mem[wr_ptr_q]    <= req_pc_q;
    end
  end

  assign bus.imem_req    = fetch_go;
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = reset_n && (count_q != '0);
  assign bus.instr       = instr_mem[rd_ptr_q];
  assign bus.instr_pc    = pc_mem[rd_ptr_q];

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: behavioural memory plus a stream model
// of which request addresses and instruction PCs must appear.
`timescale 1ns/1ps
module tb_instr_fetch;

  localparam logic [31:0] ResetPc = 32'h0000_0000;
  localparam logic [31:0] DataKey = 32'hA5A5_0000;

  logic clk;
  logic reset_n;
  instr_fetch_if bus ();

  instr_fetch #(
    .RESET_PC (ResetPc),
    .DEPTH    (2)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;
  int n_pop;
  int n_req;

  // observations of the cycle just completed
  logic        obs_req;
  logic [31:0] obs_addr;
  logic        obs_valid;
  logic [31:0] obs_instr;
  logic [31:0] obs_pc;
  logic [31:0] last_pop_pc;

  // stream model
  logic [31:0] exp_req;
  logic [31:0] exp_pc;

  // memory model
  int          mem_lat;
  bit          rand_lat;
  int          mem_cd;
  logic [31:0] mem_addr;

  task automatic cyc();
    logic        redir;
    logic [31:0] tgt;
    #4;
    obs_req   = bus.imem_req;
    obs_addr  = bus.imem_addr;
    obs_valid = bus.instr_valid;
    obs_instr = bus.instr;
    obs_pc    = bus.instr_pc;
    redir     = bus.redirect_valid;
    tgt       = {bus.redirect_pc[31:2], 2'b00};
    if (!reset_n) begin
      n_chk++;
      if (obs_req !== 1'b0 || obs_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL in_reset: req=%b valid=%b required 0/0", obs_req, obs_valid);
      end
      exp_req = ResetPc;
      exp_pc  = ResetPc;
    end else begin
      if (obs_req === 1'b1) begin
        n_req++;
        n_chk++;
        if (obs_addr !== exp_req) begin
          n_fail++;
          $display("FAIL req_addr: got %h required %h", obs_addr, exp_req);
        end
        n_chk++;
        if (mem_cd != 0 || bus.imem_rvalid) begin
          n_fail++;
          $display("FAIL one_outstanding: req at %h with response pending", obs_addr);
        end
        exp_req = exp_req + 32'd4;
      end
      if (redir) begin
        n_chk++;
        if (obs_req !== 1'b0) begin
          n_fail++;
          $display("FAIL req_on_redirect: got %b required 0", obs_req);
        end
      end else if (obs_valid === 1'b1 && bus.instr_ready) begin
        n_pop++;
        last_pop_pc = obs_pc;
        n_chk++;
        if (obs_pc !== exp_pc || obs_instr !== (exp_pc ^ DataKey)) begin
          n_fail++;
          $display("FAIL deliver: got pc=%h instr=%h required pc=%h instr=%h",
                   obs_pc, obs_instr, exp_pc, exp_pc ^ DataKey);
        end
        exp_pc = exp_pc + 32'd4;
      end
      if (redir) begin
        exp_req = tgt;
        exp_pc  = tgt;
      end
    end
    @(posedge clk);
    #1;
    bus.redirect_valid = 1'b0;
    bus.imem_rvalid    = 1'b0;
    bus.imem_rdata     = 32'hDEAD_BEEF;
    if (!reset_n) begin
      mem_cd = 0;
    end else begin
      if (obs_req === 1'b1) begin
        mem_addr = obs_addr;
        mem_cd   = rand_lat ? int'($urandom_range(1, 3)) : mem_lat;
      end
      if (mem_cd == 1) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = mem_addr ^ DataKey;
        mem_cd          = 0;
      end else if (mem_cd > 1) begin
        mem_cd--;
      end
    end
  endtask

  task automatic do_reset(input int n);
    reset_n = 1'b0;
    repeat (n) cyc();
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    bus.instr_ready = 1'b1;
    do_reset(2);
    cyc();
    n_chk++;
    if (obs_req !== 1'b1 || obs_addr !== ResetPc || obs_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_first: req=%b addr=%h valid=%b required 1/%h/0",
               obs_req, obs_addr, obs_valid, ResetPc);
    end
  endtask

  task automatic test_stream();
    mem_lat = 1;
    bus.instr_ready = 1'b1;
    do_reset(1);
    n_pop = 0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      n_chk++;
      if (obs_req !== ((i % 2) == 0)) begin
        n_fail++;
        $display("FAIL req_cadence: cycle %0d req=%b required %b", i, obs_req, (i % 2) == 0);
      end
    end
    n_chk++;
    if (n_pop != 9) begin
      n_fail++;
      $display("FAIL stream_pops: got %0d required 9", n_pop);
    end
  endtask

  task automatic test_full();
    mem_lat = 1;
    bus.instr_ready = 1'b0;
    do_reset(1);
    n_req = 0;
    repeat (12) cyc();
    n_chk++;
    if (n_req != 2 || obs_req !== 1'b0 || obs_valid !== 1'b1 || obs_pc !== 32'h0) begin
      n_fail++;
      $display("FAIL full_hold: reqs=%0d req=%b valid=%b pc=%h required 2/0/1/0",
               n_req, obs_req, obs_valid, obs_pc);
    end
    bus.instr_ready = 1'b1;
    n_pop = 0;
    repeat (6) cyc();
    n_chk++;
    if (n_pop < 2 || n_req < 3) begin
      n_fail++;
      $display("FAIL full_drain: pops=%0d reqs=%0d required >=2/>=3", n_pop, n_req);
    end
  endtask

  task automatic test_redirect_wait();
    bit found;
    int pops0;
    mem_lat = 3;
    bus.instr_ready = 1'b1;
    do_reset(1);
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      cyc();
      if (obs_req === 1'b1 && obs_addr == 32'h10) found = 1'b1;
    end
    n_chk++;
    if (!found) begin
      n_fail++;
      $display("FAIL reach_0x10: got no request to 00000010 required one");
    end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0103;
    cyc();
    cyc();
    n_chk++;
    if (obs_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL flush: instr_valid=%b required 0", obs_valid);
    end
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (obs_req === 1'b1) found = 1'b1;
      else cyc();
    end
    n_chk++;
    if (!found || obs_addr !== 32'h100) begin
      n_fail++;
      $display("FAIL redirect_addr: found=%b addr=%h required 1/00000100", found, obs_addr);
    end
    pops0 = n_pop;
    for (int i = 0; i < 12 && n_pop == pops0; i++) cyc();
    n_chk++;
    if (n_pop == pops0 || last_pop_pc !== 32'h100) begin
      n_fail++;
      $display("FAIL redirect_deliver: pc=%h required 00000100", last_pop_pc);
    end
  endtask

  task automatic test_redirect_rvalid_pop();
    bit found;
    int pops0;
    mem_lat = 1;
    bus.instr_ready = 1'b0;
    do_reset(1);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      cyc();
      if (bus.imem_rvalid === 1'b1 && bus.instr_valid === 1'b1) found = 1'b1;
    end
    n_chk++;
    if (!found) begin
      n_fail++;
      $display("FAIL setup_rvalid_pop: got no rvalid with valid head required one");
    end
    bus.instr_ready    = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h0000_0200;
    pops0 = n_pop;
    cyc();
    cyc();
    n_chk++;
    if (obs_valid !== 1'b0 || obs_req !== 1'b1 || obs_addr !== 32'h200 || n_pop != pops0) begin
      n_fail++;
      $display("FAIL redirect_rvalid_pop: valid=%b req=%b addr=%h pops=%0d required 0/1/200/%0d",
               obs_valid, obs_req, obs_addr, n_pop, pops0);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] a[2];
    int          k;
    mem_lat = 1;
    bus.instr_ready = 1'b1;
    do_reset(1);
    repeat (3) cyc();
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'hFFFF_FFFC;
    cyc();
    k = 0;
    a[0] = 32'h1;
    a[1] = 32'h1;
    for (int i = 0; i < 12 && k < 2; i++) begin
      cyc();
      if (obs_req === 1'b1) begin
        a[k] = obs_addr;
        k++;
      end
    end
    n_chk++;
    if (a[0] !== 32'hFFFF_FFFC || a[1] !== 32'h0) begin
      n_fail++;
      $display("FAIL pc_wrap: got %h,%h required fffffffc,00000000", a[0], a[1]);
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    mem_lat = 2;
    bus.instr_ready = 1'b0;
    do_reset(1);
    found = 1'b0;
    for (int i = 0; i < 12 && !found; i++) begin
      cyc();
      if (obs_req === 1'b1 && bus.instr_valid === 1'b1) found = 1'b1;
    end
    n_chk++;
    if (!found) begin
      n_fail++;
      $display("FAIL setup_wait_one: got no WAIT with one entry required one");
    end
    reset_n = 1'b0;
    cyc();
    reset_n = 1'b1;
    cyc();
    n_chk++;
    if (obs_valid !== 1'b0 || obs_req !== 1'b1 || obs_addr !== ResetPc) begin
      n_fail++;
      $display("FAIL reset_mid: valid=%b req=%b addr=%h required 0/1/%h",
               obs_valid, obs_req, obs_addr, ResetPc);
    end
  endtask

  task automatic test_random();
    rand_lat = 1'b1;
    do_reset(1);
    n_pop = 0;
    for (int i = 0; i < 600; i++) begin
      bus.instr_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 24) == 0) begin
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = $urandom;
      end
      cyc();
    end
    rand_lat = 1'b0;
    n_chk++;
    if (n_pop < 50) begin
      n_fail++;
      $display("FAIL random_progress: pops=%0d required >=50", n_pop);
    end
  endtask

  initial begin
    n_chk              = 0;
    n_fail             = 0;
    n_pop              = 0;
    n_req              = 0;
    mem_cd             = 0;
    mem_lat            = 1;
    rand_lat           = 1'b0;
    mem_addr           = '0;
    last_pop_pc        = 32'hFFFF_FFFF;
    exp_req            = ResetPc;
    exp_pc             = ResetPc;
    reset_n            = 1'b0;
    bus.imem_rvalid    = 1'b0;
    bus.imem_rdata     = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.instr_ready    = 1'b0;
    test_reset();
    test_stream();
    test_full();
    test_redirect_wait();
    test_redirect_rvalid_pop();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
